// File: rtl/pipelined_decode_unit.sv
// ID stage plus ID/EX register: register file, operand forwarding from NUM_BYPASS sources,
// immediate extension and branch/JAL target generation, with a 1-cycle registered output.
module pipelined_decode_unit #(
    parameter int CORE            = 0,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 20,
    parameter int NUM_BYPASS      = 3,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000,
    localparam int SEL_W          = $clog2(NUM_BYPASS + 1)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [ADDRESS_BITS-1:0]          PC,
    input  logic [31:0]                      instruction,
    input  logic                             in_valid,
    input  logic                             stall,
    input  logic                             flush,
    input  logic [1:0]                       extend_sel,
    input  logic                             write,
    input  logic [4:0]                       write_reg,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic [SEL_W-1:0]                 rs1_data_bypass,
    input  logic [SEL_W-1:0]                 rs2_data_bypass,
    input  logic [NUM_BYPASS*DATA_WIDTH-1:0] bypass_data,
    input  logic                             scan,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            rs1_data,
    output logic [DATA_WIDTH-1:0]            rs2_data,
    output logic [4:0]                       rd,
    output logic [6:0]                       opcode,
    output logic [2:0]                       funct3,
    output logic [6:0]                       funct7,
    output logic [DATA_WIDTH-1:0]            extend_imm,
    output logic [ADDRESS_BITS-1:0]          branch_target,
    output logic [ADDRESS_BITS-1:0]          JAL_target
);

    localparam logic [6:0] NOP_OPCODE = 7'h13;

    logic [DATA_WIDTH-1:0]   rf_reg [32];
    logic [DATA_WIDTH-1:0]   bypass_slice [NUM_BYPASS];
    logic [4:0]              rs1_idx;
    logic [4:0]              rs2_idx;
    logic [DATA_WIDTH-1:0]   rf_rs1;
    logic [DATA_WIDTH-1:0]   rf_rs2;
    logic [DATA_WIDTH-1:0]   rs1_next;
    logic [DATA_WIDTH-1:0]   rs2_next;
    logic [DATA_WIDTH-1:0]   imm_next;
    logic [12:0]             b_imm;
    logic [20:0]             j_imm;
    logic [ADDRESS_BITS-1:0] branch_next;
    logic [ADDRESS_BITS-1:0] jal_next;
    logic [31:0]             cycle_count_reg;

    assign rs1_idx = instruction[19:15];
    assign rs2_idx = instruction[24:20];

    for (genvar gi = 0; gi < NUM_BYPASS; gi++) begin : g_bypass
        assign bypass_slice[gi] = bypass_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Register file; entry 0 is never written so it stays zero after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (write && (write_reg != 5'd0)) begin
            rf_reg[write_reg] <= write_data;
        end
    end

    // Write-through so a result retiring this cycle is seen by the instruction in decode.
    always_comb begin
        rf_rs1 = rf_reg[rs1_idx];
        rf_rs2 = rf_reg[rs2_idx];
        if (rs1_idx == 5'd0) begin
            rf_rs1 = '0;
        end else if (write && (write_reg == rs1_idx)) begin
            rf_rs1 = write_data;
        end
        if (rs2_idx == 5'd0) begin
            rf_rs2 = '0;
        end else if (write && (write_reg == rs2_idx)) begin
            rf_rs2 = write_data;
        end
    end

    // Out-of-range selects fall back to the register file value.
    always_comb begin
        rs1_next = rf_rs1;
        rs2_next = rf_rs2;
        for (int k = 0; k < NUM_BYPASS; k++) begin
            if (int'(rs1_data_bypass) == k + 1) rs1_next = bypass_slice[k];
            if (int'(rs2_data_bypass) == k + 1) rs2_next = bypass_slice[k];
        end
    end

    always_comb begin
        imm_next = '0;
        case (extend_sel)
            2'b00:   imm_next = DATA_WIDTH'($signed(instruction[31:20]));
            2'b01:   imm_next = DATA_WIDTH'($signed({instruction[31:25], instruction[11:7]}));
            2'b10:   imm_next = DATA_WIDTH'($signed({instruction[31:12], 12'b0}));
            default: imm_next = DATA_WIDTH'(instruction[31:20]);
        endcase
    end

    assign b_imm = {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
    assign j_imm = {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};
    assign branch_next = PC + ADDRESS_BITS'($signed(b_imm));
    assign jal_next    = PC + ADDRESS_BITS'($signed(j_imm));

    // ID/EX register: flush beats stall, stall holds everything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            rs1_data      <= '0;
            rs2_data      <= '0;
            rd            <= '0;
            opcode        <= NOP_OPCODE;
            funct3        <= '0;
            funct7        <= '0;
            extend_imm    <= '0;
            branch_target <= '0;
            JAL_target    <= '0;
        end else if (flush) begin
            out_valid     <= 1'b0;
            rs1_data      <= '0;
            rs2_data      <= '0;
            rd            <= '0;
            opcode        <= NOP_OPCODE;
            funct3        <= '0;
            funct7        <= '0;
            extend_imm    <= '0;
            branch_target <= '0;
            JAL_target    <= '0;
        end else if (!stall) begin
            out_valid     <= in_valid;
            rs1_data      <= rs1_next;
            rs2_data      <= rs2_next;
            rd            <= instruction[11:7];
            opcode        <= instruction[6:0];
            funct3        <= instruction[14:12];
            funct7        <= instruction[31:25];
            extend_imm    <= imm_next;
            branch_target <= branch_next;
            JAL_target    <= jal_next;
        end
    end

    // Free-running cycle count kept for debug scan tooling; it does not affect decode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count_reg <= '0;
        end else begin
            cycle_count_reg <= cycle_count_reg + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipelined_decode_unit.sv
// Directed bench for pipelined_decode_unit: reset, RF write/write-through, bypass select,
// immediates, branch/JAL targets, stall/flush and asynchronous reset.
module tb_pipelined_decode_unit;

    localparam int DW = 32;
    localparam int AB = 20;
    localparam int NB = 3;
    localparam int SW = 2;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] ADD_155 = 32'h0052_80B3;  // add x1,x5,x5
    localparam logic [31:0] ADD_266 = 32'h0063_0133;  // add x2,x6,x6
    localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;  // beq x0,x0,-8
    localparam logic [31:0] JAL_800 = 32'h0010_00EF;  // jal x1,+0x800
    localparam logic [31:0] MIXED   = 32'h8765_4A13;

    logic              clock = 1'b0;
    logic              reset;
    logic [AB-1:0]     PC;
    logic [31:0]       instruction;
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [1:0]        extend_sel;
    logic              write;
    logic [4:0]        write_reg;
    logic [DW-1:0]     write_data;
    logic [SW-1:0]     rs1_data_bypass;
    logic [SW-1:0]     rs2_data_bypass;
    logic [NB*DW-1:0]  bypass_data;
    logic              scan;
    logic              out_valid;
    logic [DW-1:0]     rs1_data;
    logic [DW-1:0]     rs2_data;
    logic [4:0]        rd;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [DW-1:0]     extend_imm;
    logic [AB-1:0]     branch_target;
    logic [AB-1:0]     JAL_target;

    int checks = 0;
    int errors = 0;

    pipelined_decode_unit #(
        .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .NUM_BYPASS(NB),
        .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)
    ) dut (
        .clock(clock), .reset(reset), .PC(PC), .instruction(instruction),
        .in_valid(in_valid), .stall(stall), .flush(flush), .extend_sel(extend_sel),
        .write(write), .write_reg(write_reg), .write_data(write_data),
        .rs1_data_bypass(rs1_data_bypass), .rs2_data_bypass(rs2_data_bypass),
        .bypass_data(bypass_data), .scan(scan), .out_valid(out_valid),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .extend_imm(extend_imm),
        .branch_target(branch_target), .JAL_target(JAL_target)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; PC = '0; instruction = NOP; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        extend_sel = 2'b00; write = 1'b0; write_reg = '0; write_data = '0;
        rs1_data_bypass = '0; rs2_data_bypass = '0; bypass_data = '0; scan = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (opcode !== 7'h13) begin errors++; $display("FAIL reset_opcode: got %h expected 13", opcode); end
        checks++; if (rs1_data !== 32'h0 || extend_imm !== 32'h0 || JAL_target !== 20'h0) begin
            errors++; $display("FAIL reset_data: rs1 %h imm %h jal %h expected all 0", rs1_data, extend_imm, JAL_target); end
        reset = 1'b1;
        instruction = NOP; in_valid = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nop_valid: got %b expected 1", out_valid); end
        checks++; if (opcode !== 7'h13 || rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            errors++; $display("FAIL nop_decode: opcode %h rs1 %h rs2 %h expected 13 0 0", opcode, rs1_data, rs2_data); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nop_invalid: got %b expected 0", out_valid); end
        $display("test_reset done");
    endtask

    task automatic test_regfile();
        in_valid = 1'b1; instruction = NOP;
        write = 1'b1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF;
        step();
        write = 1'b0; instruction = ADD_155;
        step();
        checks++; if (rs1_data !== 32'hDEAD_BEEF || rs2_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rf_read: rs1 %h rs2 %h expected deadbeef", rs1_data, rs2_data); end
        checks++; if (rd !== 5'd1 || opcode !== 7'h33 || funct3 !== 3'd0 || funct7 !== 7'd0) begin
            errors++; $display("FAIL add_fields: rd %h op %h f3 %h f7 %h expected 1 33 0 0", rd, opcode, funct3, funct7); end
        write = 1'b1; write_reg = 5'd6; write_data = 32'h1234_5678; instruction = ADD_266;
        step();
        checks++; if (rs1_data !== 32'h1234_5678 || rs2_data !== 32'h1234_5678) begin
            errors++; $display("FAIL write_through: rs1 %h rs2 %h expected 12345678", rs1_data, rs2_data); end
        write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF; instruction = NOP;
        step();
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_write_through: got %h expected 0", rs1_data); end
        write = 1'b0; instruction = ADD_266;
        step();
        checks++; if (rs1_data !== 32'h1234_5678) begin errors++; $display("FAIL rf_held: got %h expected 12345678", rs1_data); end
        $display("test_regfile done");
    endtask

    task automatic test_bypass();
        logic [1:0] s1 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [1:0] s2 [4] = '{2'd2, 2'd3, 2'd1, 2'd0};
        logic [31:0] e1 [4] = '{32'd1, 32'd2, 32'd3, 32'hDEAD_BEEF};
        logic [31:0] e2 [4] = '{32'd2, 32'd3, 32'd1, 32'hDEAD_BEEF};
        bypass_data = {32'd3, 32'd2, 32'd1};
        instruction = ADD_155;
        for (int i = 0; i < 4; i++) begin
            rs1_data_bypass = s1[i]; rs2_data_bypass = s2[i];
            step();
            checks++; if (rs1_data !== e1[i] || rs2_data !== e2[i]) begin
                errors++; $display("FAIL bypass_%0d: got %h/%h expected %h/%h", i, rs1_data, rs2_data, e1[i], e2[i]); end
        end
        instruction = NOP; rs1_data_bypass = 2'd0; rs2_data_bypass = 2'd0;
        step();
        checks++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            errors++; $display("FAIL x0_sel0: got %h/%h expected 0/0", rs1_data, rs2_data); end
        rs1_data_bypass = 2'd1; rs2_data_bypass = 2'd3;
        step();
        checks++; if (rs1_data !== 32'd1 || rs2_data !== 32'd3) begin
            errors++; $display("FAIL x0_bypass: got %h/%h expected 1/3", rs1_data, rs2_data); end
        rs1_data_bypass = 2'd0; rs2_data_bypass = 2'd0;
        $display("test_bypass done");
    endtask

    task automatic test_targets();
        PC = 20'h00010; instruction = BEQ_M8; extend_sel = 2'b00;
        step();
        checks++; if (branch_target !== 20'h00008) begin errors++; $display("FAIL beq_target: got %h expected 00008", branch_target); end
        checks++; if (funct7 !== 7'h7F || opcode !== 7'h63) begin
            errors++; $display("FAIL beq_fields: f7 %h op %h expected 7f 63", funct7, opcode); end
        checks++; if (extend_imm !== 32'hFFFF_FFE0) begin errors++; $display("FAIL beq_iimm: got %h expected ffffffe0", extend_imm); end
        PC = 20'hFFFFC; instruction = JAL_800;
        step();
        checks++; if (JAL_target !== 20'h007FC) begin errors++; $display("FAIL jal_wrap: got %h expected 007fc", JAL_target); end
        checks++; if (branch_target !== 20'h007FC) begin errors++; $display("FAIL jal_btarget: got %h expected 007fc", branch_target); end
        PC = '0;
        $display("test_targets done");
    endtask

    task automatic test_extend();
        logic [31:0] exp_imm [4] = '{32'hFFFF_F876, 32'hFFFF_F874, 32'h8765_4000, 32'h0000_0876};
        instruction = MIXED;
        for (int i = 0; i < 4; i++) begin
            extend_sel = 2'(i);
            step();
            checks++; if (extend_imm !== exp_imm[i]) begin
                errors++; $display("FAIL extend_sel%0d: got %h expected %h", i, extend_imm, exp_imm[i]); end
        end
        checks++; if (rd !== 5'h14 || funct3 !== 3'd4 || funct7 !== 7'h43 || opcode !== 7'h13) begin
            errors++; $display("FAIL mixed_fields: rd %h f3 %h f7 %h op %h expected 14 4 43 13", rd, funct3, funct7, opcode); end
        extend_sel = 2'b00;
        $display("test_extend done");
    endtask

    task automatic test_stall_flush();
        in_valid = 1'b1; instruction = ADD_155;
        step();
        checks++; if (out_valid !== 1'b1 || rs1_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL pre_stall: valid %b rs1 %h expected 1 deadbeef", out_valid, rs1_data); end
        stall = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            instruction = (i == 0) ? MIXED : (i == 1) ? BEQ_M8 : JAL_800;
            rs1_data_bypass = 2'(i + 1);
            step();
            checks++; if (out_valid !== 1'b1 || rs1_data !== 32'hDEAD_BEEF || rd !== 5'd1 || opcode !== 7'h33) begin
                errors++; $display("FAIL stall_hold_%0d: valid %b rs1 %h rd %h op %h expected 1 deadbeef 1 33", i, out_valid, rs1_data, rd, opcode); end
        end
        flush = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || opcode !== 7'h13 || rd !== 5'd0 || rs1_data !== 32'h0 || JAL_target !== 20'h0) begin
            errors++; $display("FAIL flush_stall: valid %b op %h rd %h rs1 %h jal %h expected 0 13 0 0 0", out_valid, opcode, rd, rs1_data, JAL_target); end
        flush = 1'b0; stall = 1'b0; rs1_data_bypass = 2'd0;
        $display("test_stall_flush done");
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; instruction = ADD_155;
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", out_valid); end
        #2 reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || opcode !== 7'h13 || rs1_data !== 32'h0 || rd !== 5'd0) begin
            errors++; $display("FAIL async_reset: valid %b op %h rs1 %h rd %h expected 0 13 0 0", out_valid, opcode, rs1_data, rd); end
        #2 reset = 1'b1;
        step();
        checks++; if (rs1_data !== 32'h0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL rf_cleared: rs1 %h valid %b expected 0 1", rs1_data, out_valid); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_regfile();
        test_bypass();
        test_targets();
        test_extend();
        test_stall_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
